// File: rtl/fixed_alu_seq.sv
// fixed_alu_seq: sequential unsigned fixed-point add/sub/mul/mac unit with a start/busy/done handshake.
// Optional build macro FIXED_ALU_SATURATE_EN: on overflow the result saturates instead of wrapping.
module fixed_alu_seq #(
  parameter int INT_W          = 8,
  parameter int FRAC_W         = 8,
  parameter int ACC_CLR_ON_RST = 1,
  localparam int W             = INT_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  input  logic         acc_clr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         precision_lost,
  output logic [W-1:0] acc
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [2*W-1:0] LOW_MASK = ((2*W)'(1) << FRAC_W) - (2*W)'(1);
  typedef enum logic [1:0] {IDLE, ADDSUB, MUL, FIN} state_t;
  state_t state, state_nx;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] product;
  logic [CW-1:0]  cnt;
  logic [W:0]     addsub, mac_sum;
  logic [W-1:0]   p, fin_val, as_res, fin_res, acc_nx;
  logic           prod_ovf, prec, fin_ovf;
  assign busy = (state != IDLE);
  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Next-state: add/sub takes one cycle, mul/mac walks every multiplier bit then finishes.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (op[1] ? MUL : ADDSUB) : IDLE;
      ADDSUB:  state_nx = IDLE;
      MUL:     state_nx = (cnt == CNT_LAST) ? FIN : MUL;
      default: state_nx = IDLE;
    endcase
  end
  // Result arithmetic: W+1-bit add/sub, product slicing and the mac sum.
  always_comb begin
    addsub   = op_q[0] ? {1'b0, a_q} - {1'b0, b_q} : {1'b0, a_q} + {1'b0, b_q};
    p        = product[FRAC_W +: W];
    prec     = |(product & LOW_MASK);
    prod_ovf = |(product >> (W + FRAC_W));
    mac_sum  = {1'b0, acc} + {1'b0, p};
    fin_ovf  = prod_ovf | (op_q[0] & mac_sum[W]);
    fin_val  = op_q[0] ? mac_sum[W-1:0] : p;
`ifdef FIXED_ALU_SATURATE_EN
    as_res   = addsub[W] ? (op_q[0] ? '0 : '1) : addsub[W-1:0];
    fin_res  = fin_ovf ? '1 : fin_val;
`else
    as_res   = addsub[W-1:0];
    fin_res  = fin_val;
`endif
    acc_nx   = (state == IDLE && acc_clr) ? '0 :
               (state == FIN && op_q == 2'b11) ? fin_res : acc;
  end
  // Operand capture, shift-add product accumulation and registered result/flags.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      product        <= '0;
      cnt            <= '0;
      result         <= '0;
      overflow       <= 1'b0;
      precision_lost <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q    <= op;
          a_q     <= num1;
          b_q     <= num2;
          product <= '0;
          cnt     <= '0;
        end
        ADDSUB: begin
          result         <= as_res;
          overflow       <= addsub[W];
          precision_lost <= 1'b0;
          done           <= 1'b1;
        end
        MUL: begin
          if (b_q[cnt]) product <= product + ({{W{1'b0}}, a_q} << cnt);
          cnt <= cnt + CW'(1);
        end
        default: begin
          result         <= fin_res;
          overflow       <= fin_ovf;
          precision_lost <= prec;
          done           <= 1'b1;
        end
      endcase
    end
  generate
    if (ACC_CLR_ON_RST != 0) begin : g_acc_rst
      // Accumulator, cleared by reset.
      always_ff @(posedge clk or negedge rst)
        if (!rst) acc <= '0;
        else acc <= acc_nx;
    end else begin : g_acc_norst
      // Accumulator without reset; its power-up value is left undefined.
      always_ff @(posedge clk)
        acc <= acc_nx;
    end
  endgenerate
endmodule

// File: tb/tb_fixed_alu_seq.sv
// tb_fixed_alu_seq: directed and randomized checks of fixed_alu_seq against an arithmetic model.
module tb_fixed_alu_seq;
  localparam int W = 16;
  localparam int F = 8;
  localparam longint unsigned MAXV = 64'hFFFF;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, acc_clr = 1'b0;
  logic [1:0] op = '0;
  logic [W-1:0] num1 = '0, num2 = '0;
  logic busy, done, overflow, precision_lost;
  logic [W-1:0] result, acc;
  int passed = 0, total = 0;
  longint unsigned m_acc = 0;
  always #5 clk = ~clk;
  fixed_alu_seq #(.INT_W(8), .FRAC_W(F), .ACC_CLR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .acc_clr(acc_clr), .busy(busy), .done(done), .result(result),
    .overflow(overflow), .precision_lost(precision_lost), .acc(acc)
  );
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Expected result from plain integer arithmetic; updates the model accumulator for mac.
  task automatic model(input logic [1:0] o, input longint unsigned a, input longint unsigned b,
                       output longint unsigned res, output longint unsigned ov, output longint unsigned pl);
    longint unsigned full, pv, s;
    pl = 0;
    if (o == 2'd0) begin
      s = a + b; ov = (s > MAXV) ? 1 : 0; res = s & MAXV;
    end else if (o == 2'd1) begin
      ov = (a < b) ? 1 : 0; res = (a - b) & MAXV;
    end else begin
      full = a * b;
      pv = (full >> F) & MAXV;
      pl = ((full & 64'hFF) != 0) ? 1 : 0;
      ov = ((full >> (W + F)) != 0) ? 1 : 0;
      if (o == 2'd3) begin
        s = m_acc + pv;
        if (s > MAXV) ov = 1;
        res = s & MAXV;
      end else res = pv;
    end
`ifdef FIXED_ALU_SATURATE_EN
    if (ov != 0) res = (o == 2'd1) ? 0 : MAXV;
`endif
    if (o == 2'd3) m_acc = res;
  endtask
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit clr, input bit noise, input string tag);
    longint unsigned er, eo, ep;
    int n, nb, both;
    logic [W-1:0] r_hold;
    if (clr) m_acc = 0;
    model(o, a, b, er, eo, ep);
    @(negedge clk);
    start = 1'b1; op = o; num1 = a; num2 = b; acc_clr = clr;
    @(negedge clk);
    start = 1'b0; acc_clr = 1'b0;
    n = 1; nb = 0; both = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (noise && $urandom_range(2) == 0) begin
        start = 1'b1; op = 2'($urandom); num1 = W'($urandom); num2 = W'($urandom);
        acc_clr = 1'($urandom);
      end else begin
        start = 1'b0; acc_clr = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy && done) both++;
    end
    start = 1'b0; acc_clr = 1'b0;
    check($sformatf("%s done_seen", tag), done, 1);
    check($sformatf("%s latency", tag), n, o[1] ? W + 2 : 2);
    check($sformatf("%s busy_cycles", tag), nb, n - 1);
    check($sformatf("%s busy_done_overlap", tag), both, 0);
    check($sformatf("%s result", tag), result, er);
    check($sformatf("%s overflow", tag), overflow, eo);
    check($sformatf("%s precision_lost", tag), precision_lost, ep);
    check($sformatf("%s acc", tag), acc, m_acc);
    r_hold = result;
    @(negedge clk);
    check($sformatf("%s single_done", tag), done, 0);
    check($sformatf("%s result_hold", tag), result, r_hold);
  endtask
  initial begin
    int dseen;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset acc", acc, 0);
    check("reset flags", {overflow, precision_lost}, 0);
    @(negedge clk); rst = 1'b1;
    run(2'd0, 16'h001B, 16'h002A, 1'b0, 1'b0, "add");
    run(2'd2, 16'h0231, 16'h009E, 1'b0, 1'b0, "mul");
    run(2'd1, 16'h0045, 16'h0100, 1'b0, 1'b0, "sub_under");
    run(2'd2, 16'h1000, 16'h1000, 1'b0, 1'b0, "mul_ovf");
    run(2'd3, 16'h0200, 16'h0300, 1'b1, 1'b0, "mac1");
    run(2'd3, 16'h0200, 16'h0300, 1'b0, 1'b1, "mac2");
    run(2'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, "add_carry");
    run(2'd1, 16'h0100, 16'h0100, 1'b0, 1'b0, "sub_zero");
    for (int i = 0; i < 30; i++) begin
      logic [1:0] o;
      logic [W-1:0] a, b;
      o = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if (o[1] && $urandom_range(1) == 0) begin
        a = W'($urandom_range(16'h0800));
        b = W'($urandom_range(16'h0800));
      end
      run(o, a, b, ($urandom_range(3) == 0), 1'b1, $sformatf("rnd%0d", i));
    end
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0; m_acc = 0;
    check("idle acc_clr", acc, 0);
    run(2'd3, 16'h0300, 16'h0500, 1'b0, 1'b0, "mac_pre_rst");
    @(negedge clk);
    start = 1'b1; op = 2'd2; num1 = 16'h1234; num2 = 16'h00FF;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0; m_acc = 0;
    #1;
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    check("rst_mid result", result, 0);
    check("rst_mid acc", acc, 0);
    check("rst_mid flags", {overflow, precision_lost}, 0);
    @(negedge clk); rst = 1'b1;
    dseen = 0;
    repeat (24) begin
      @(negedge clk);
      if (done) dseen++;
    end
    check("rst_mid no_done", dseen, 0);
    run(2'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, "add_after_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
